// File: rtl/jpeg_block_sequencer_if.sv
// jpeg_block_sequencer_if: pixel stream handshake and stage-strobe bundle for jpeg_block_sequencer
interface jpeg_block_sequencer_if #(
  parameter int PIX_WIDTH = 8,
  parameter int BLK_DIM   = 8
);
  localparam int N     = BLK_DIM * BLK_DIM;
  localparam int ROW_W = $clog2(BLK_DIM);
  logic                   pix_valid;
  logic                   pix_ready;
  logic [PIX_WIDTH-1:0]   pix_data;
  logic [1:0]             mode;
  logic [N*PIX_WIDTH-1:0] blk_pix;
  logic                   dct_enable;
  logic                   dct_input_enable;
  logic [ROW_W-1:0]       matrix_row;
  logic                   zigzag_input_enable;
  logic                   is_luminance;
  logic [1:0]             comp_id;
  logic                   blk_done;
  logic                   mcu_done;
  logic                   busy;
  modport master (
    output pix_valid, pix_data, mode,
    input  pix_ready, blk_pix, dct_enable, dct_input_enable, matrix_row,
           zigzag_input_enable, is_luminance, comp_id, blk_done, mcu_done, busy
  );
  modport slave (
    input  pix_valid, pix_data, mode,
    output pix_ready, blk_pix, dct_enable, dct_input_enable, matrix_row,
           zigzag_input_enable, is_luminance, comp_id, blk_done, mcu_done, busy
  );
endinterface

// File: rtl/jpeg_block_sequencer.sv
// jpeg_block_sequencer: fills an 8x8 pixel block and self-times DCT/quantize/zigzag strobes; JPEG_SEQ_SUBSAMPLE_420_EN enables Y,Y,Y,Y,Cb,Cr sequencing for mode 10
module jpeg_block_sequencer #(
  parameter int PIX_WIDTH = 8,
  parameter int BLK_DIM   = 8,
  parameter int DCT_LAT   = 4,
  parameter int QUANT_LAT = 1
) (
  input logic clock,
  input logic reset,
  jpeg_block_sequencer_if.slave bus
);
  localparam int N     = BLK_DIM * BLK_DIM;
  localparam int ROW_W = $clog2(BLK_DIM);
  localparam int FW    = $clog2(N);
  localparam int CMAX  = DCT_LAT > QUANT_LAT + 1 ? DCT_LAT : QUANT_LAT + 1;
  localparam int CW    = $clog2(CMAX + 1);
  localparam logic [FW-1:0] LAST_PIX = FW'(N - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(BLK_DIM - 1);
  typedef enum logic [2:0] {S_IDLE, S_DCT, S_WAIT, S_CAP, S_ROW, S_DONE} state_t;
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic [FW-1:0]          fill_q;
  logic                   buf_full_q, buf_full_d, pix_ready_q;
  logic [N*PIX_WIDTH-1:0] buf_q, blk_q;
  logic [1:0]             mode_q, eff_mode, comp_q, comp_new;
  logic [2:0]             seq_q, cur_q, idx, last_idx;
  logic                   last_q, accept, start;
  assign accept     = bus.pix_valid && pix_ready_q;
  assign start      = state_q == S_IDLE && buf_full_q;
  assign buf_full_d = (buf_full_q && !start) || (accept && fill_q == LAST_PIX);
  assign idx        = eff_mode != mode_q ? 3'd0 : seq_q;
`ifdef JPEG_SEQ_SUBSAMPLE_420_EN
  // 4:2:0 walks four luma blocks, then Cb (idx 4) and Cr (idx 5)
  always_comb begin
    eff_mode = bus.mode == 2'b11 ? 2'b00 : bus.mode;
    comp_new = eff_mode == 2'b10 ? (idx < 3'd4 ? 2'd0 : idx[1:0] + 2'd1) :
               eff_mode == 2'b01 ? idx[1:0] : 2'd0;
    last_idx = eff_mode == 2'b10 ? 3'd5 : eff_mode == 2'b01 ? 3'd2 : 3'd0;
  end
`else
  // without 4:2:0 support, mode 10 folds onto 4:4:4 so switching between them keeps the sequence
  always_comb begin
    eff_mode = bus.mode == 2'b11 ? 2'b00 : bus.mode == 2'b10 ? 2'b01 : bus.mode;
    comp_new = eff_mode == 2'b01 ? idx[1:0] : 2'd0;
    last_idx = eff_mode == 2'b01 ? 3'd2 : 3'd0;
  end
`endif
  // fill side: raster write into the input buffer, ready drops while a full block waits
  always_ff @(posedge clock) begin
    if (reset) begin
      fill_q      <= '0;
      buf_full_q  <= 1'b0;
      pix_ready_q <= 1'b0;
    end else begin
      if (accept) begin
        buf_q[fill_q*PIX_WIDTH +: PIX_WIDTH] <= bus.pix_data;
        fill_q <= fill_q == LAST_PIX ? '0 : fill_q + 1'b1;
      end
      buf_full_q  <= buf_full_d;
      pix_ready_q <= !buf_full_d;
    end
  end
  // block transfer latches pixels and component; sequence position advances when the block finishes
  always_ff @(posedge clock) begin
    if (reset) begin
      blk_q  <= '0;
      mode_q <= 2'b00;
      comp_q <= 2'd0;
      cur_q  <= 3'd0;
      seq_q  <= 3'd0;
      last_q <= 1'b0;
    end else if (start) begin
      blk_q  <= buf_q;
      mode_q <= eff_mode;
      comp_q <= comp_new;
      cur_q  <= idx;
      last_q <= idx == last_idx;
    end else if (state_q == S_DONE) begin
      seq_q <= last_q ? 3'd0 : cur_q + 3'd1;
    end
  end
  // process state, stage counter and row index registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
    end
  end
  // stage sequencing: DCT start, fixed DCT wait, capture, then rows of QUANT_LAT+1 cycles
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    case (state_q)
      S_IDLE: state_d = buf_full_q ? S_DCT : S_IDLE;
      S_DCT: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        cnt_d   = cnt_q == CW'(DCT_LAT - 1) ? '0 : cnt_q + 1'b1;
        state_d = cnt_q == CW'(DCT_LAT - 1) ? S_CAP : S_WAIT;
      end
      S_CAP: state_d = S_ROW;
      S_ROW: begin
        cnt_d = cnt_q == CW'(QUANT_LAT) ? '0 : cnt_q + 1'b1;
        if (cnt_q == CW'(QUANT_LAT)) begin
          row_d   = row_q == LAST_ROW ? '0 : row_q + 1'b1;
          state_d = row_q == LAST_ROW ? S_DONE : S_ROW;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  assign bus.pix_ready           = pix_ready_q;
  assign bus.blk_pix             = blk_q;
  assign bus.dct_enable          = state_q == S_DCT;
  assign bus.dct_input_enable    = state_q == S_CAP;
  assign bus.matrix_row          = row_q;
  assign bus.zigzag_input_enable = state_q == S_ROW && cnt_q == CW'(QUANT_LAT);
  assign bus.comp_id             = comp_q;
  assign bus.is_luminance        = comp_q == 2'd0;
  assign bus.blk_done            = state_q == S_DONE;
  assign bus.mcu_done            = state_q == S_DONE && last_q;
  assign bus.busy                = state_q != S_IDLE;
endmodule

// File: tb/tb_jpeg_block_sequencer.sv
// tb_jpeg_block_sequencer: table vectors plus cycle-level reference model for jpeg_block_sequencer
module tb_jpeg_block_sequencer;
  localparam int PW = 8, BD = 8, DL = 4, QL = 1;
  localparam int N = BD * BD, BW = N * PW;
  localparam int PROC = 4 + DL + BD * (QL + 1);
  logic clock = 1'b0;
  logic reset;
  int checks = 0, errors = 0;
  jpeg_block_sequencer_if #(.PIX_WIDTH(PW), .BLK_DIM(BD)) bus ();
  jpeg_block_sequencer #(.PIX_WIDTH(PW), .BLK_DIM(BD), .DCT_LAT(DL), .QUANT_LAT(QL)) dut (
    .clock(clock), .reset(reset), .bus(bus.slave)
  );
  always #5 clock = ~clock;
  task automatic chk(input string nm, input logic [BW-1:0] a, input logic [BW-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, a, e, $time);
    end
  endtask
  function automatic int eff_of(input logic [1:0] m);
    if (m == 2'b11) return 0;
`ifdef JPEG_SEQ_SUBSAMPLE_420_EN
    return int'(m);
`else
    return m == 2'b10 ? 1 : int'(m);
`endif
  endfunction
  function automatic int seq_len(input int em);
    return em == 2 ? 6 : em == 1 ? 3 : 1;
  endfunction
  function automatic int seq_comp(input int em, input int p);
    int s420[6] = '{0, 0, 0, 0, 1, 2};
    return em == 2 ? s420[p] : em == 1 ? p : 0;
  endfunction
  // reference model state
  int cyc = 0, t_last = -1000, pos = 0, last_mode = 0, exp_comp = 0, k;
  bit rs = 1'b1, exp_mcu = 1'b0;
  logic [PW-1:0] acc_q[$];
  logic [BW-1:0] exp_blk = '0, nxt_blk = '0;
  int done_comp[$];
  bit done_mcu[$], done_lum[$];
  int dct_cyc = 0, cap_cyc = 0, done_cyc = 0, zz_cnt = 0;
  always @(posedge clock) begin
    cyc <= cyc + 1;
    rs  <= reset;
  end
  always @(negedge clock) begin
    if (rs) begin
      chk("rst_ready", bus.pix_ready, 0);
      chk("rst_dct", bus.dct_enable, 0);
      chk("rst_cap", bus.dct_input_enable, 0);
      chk("rst_zz", bus.zigzag_input_enable, 0);
      chk("rst_done", bus.blk_done, 0);
      chk("rst_mcu", bus.mcu_done, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_row", bus.matrix_row, 0);
      chk("rst_comp", bus.comp_id, 0);
      chk("rst_lum", bus.is_luminance, 1);
      chk("rst_blk", bus.blk_pix, 0);
      acc_q.delete();
      t_last = -1000; pos = 0; last_mode = 0; exp_comp = 0; exp_mcu = 0; exp_blk = '0;
    end else begin
      k = cyc - (t_last + 4 + DL);
      chk("pix_ready", bus.pix_ready, cyc != t_last + 1);
      chk("dct_enable", bus.dct_enable, cyc == t_last + 2);
      chk("dct_input_enable", bus.dct_input_enable, cyc == t_last + 3 + DL);
      chk("zigzag", bus.zigzag_input_enable, k >= 0 && k < BD * (QL + 1) && k % (QL + 1) == QL);
      chk("blk_done", bus.blk_done, cyc == t_last + PROC);
      chk("mcu_done", bus.mcu_done, cyc == t_last + PROC && exp_mcu);
      chk("busy", bus.busy, cyc >= t_last + 2 && cyc <= t_last + PROC);
      if (k >= 0 && k < BD * (QL + 1)) chk("matrix_row", bus.matrix_row, k / (QL + 1));
      chk("comp_id", bus.comp_id, exp_comp);
      chk("is_luminance", bus.is_luminance, exp_comp == 0);
      chk("blk_pix", bus.blk_pix, exp_blk);
      if (bus.dct_enable) dct_cyc = cyc;
      if (bus.dct_input_enable) cap_cyc = cyc;
      if (bus.zigzag_input_enable) zz_cnt++;
      if (bus.blk_done) begin
        done_cyc = cyc;
        done_comp.push_back(int'(bus.comp_id));
        done_mcu.push_back(bus.mcu_done);
        done_lum.push_back(bus.is_luminance);
      end
      if (cyc == t_last + 1) begin
        if (eff_of(bus.mode) != last_mode) pos = 0;
        last_mode = eff_of(bus.mode);
        exp_comp = seq_comp(last_mode, pos);
        exp_mcu = pos == seq_len(last_mode) - 1;
        pos = (pos + 1) % seq_len(last_mode);
        exp_blk = nxt_blk;
      end
      if (bus.pix_valid && bus.pix_ready) begin
        acc_q.push_back(bus.pix_data);
        if (acc_q.size() == N) begin
          for (int i = 0; i < N; i++) nxt_blk[i*PW +: PW] = acc_q[i];
          acc_q.delete();
          t_last = cyc;
        end
      end
    end
  end
  // streams n pixels; returns one cycle after the last accept so mode stays put through transfer
  task automatic send_block(input logic [1:0] m, input int base, input bit gaps, input int n);
    int i = 0, guard = 0;
    bus.mode = m;
    while (i < n && guard < 2000) begin
      bus.pix_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.pix_data  = gaps ? PW'($urandom) : PW'(base + i);
      @(negedge clock);
      if (bus.pix_valid && bus.pix_ready) i++;
      @(posedge clock); #1;
      guard++;
    end
    bus.pix_valid = 1'b0;
    if (i < n) begin
      errors++;
      $display("FAIL send_block timeout: got %0d accepts expected %0d", i, n);
    end
    @(posedge clock); #1;
  endtask
  task automatic pulse_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1;
  endtask
  typedef struct { logic [1:0] mode; int comp; bit mcu; } vec_t;
  vec_t tab[14];
  task automatic set_vec(input int i, input logic [1:0] m, input int c, input bit mc);
    tab[i].mode = m; tab[i].comp = c; tab[i].mcu = mc;
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
  initial begin
    int n0, guard;
    logic [BW-1:0] ramp;
    set_vec(0, 2'b00, 0, 1); set_vec(1, 2'b00, 0, 1);
    set_vec(2, 2'b01, 0, 0); set_vec(3, 2'b01, 1, 0); set_vec(4, 2'b01, 2, 1);
    set_vec(5, 2'b01, 0, 0); set_vec(6, 2'b00, 0, 1);
`ifdef JPEG_SEQ_SUBSAMPLE_420_EN
    set_vec(7, 2'b10, 0, 0); set_vec(8, 2'b10, 0, 0); set_vec(9, 2'b10, 0, 0);
    set_vec(10, 2'b10, 0, 0); set_vec(11, 2'b10, 1, 0); set_vec(12, 2'b10, 2, 1);
`else
    set_vec(7, 2'b10, 0, 0); set_vec(8, 2'b10, 1, 0); set_vec(9, 2'b10, 2, 1);
    set_vec(10, 2'b10, 0, 0); set_vec(11, 2'b10, 1, 0); set_vec(12, 2'b10, 2, 1);
`endif
    set_vec(13, 2'b11, 0, 1);
    bus.pix_valid = 1'b0; bus.pix_data = '0; bus.mode = 2'b00;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1;
    chk("ready_after_reset", bus.pix_ready, 1);
    // gray ramp block with exact strobe latencies
    zz_cnt = 0;
    send_block(2'b00, 0, 1'b0, N);
    repeat (30) @(posedge clock);
    #1;
    for (int i = 0; i < N; i++) ramp[i*PW +: PW] = PW'(i);
    chk("ramp_blk_pix", bus.blk_pix, ramp);
    chk("dct_latency", dct_cyc - t_last, 2);
    chk("cap_latency", cap_cyc - t_last, 7);
    chk("done_latency", done_cyc - t_last, 24);
    chk("zigzag_count", zz_cnt, 8);
    chk("gray_mcu", done_mcu[done_mcu.size()-1], 1);
    // component sequencing table, back-to-back, odd entries with random valid gaps
    n0 = done_comp.size();
    for (int i = 0; i < 14; i++) send_block(tab[i].mode, i * 16, i % 2 == 1, N);
    repeat (40) @(posedge clock);
    #1;
    chk("table_done_count", done_comp.size() - n0, 14);
    for (int i = 0; i < 14 && n0 + i < done_comp.size(); i++) begin
      chk($sformatf("tab%0d_comp", i), done_comp[n0+i], tab[i].comp);
      chk($sformatf("tab%0d_mcu", i), done_mcu[n0+i], tab[i].mcu);
      chk($sformatf("tab%0d_lum", i), done_lum[n0+i], tab[i].comp == 0);
    end
    // reset while rows are being sequenced
    send_block(2'b01, 7, 1'b0, N);
    guard = 0;
    do begin
      @(negedge clock);
      guard++;
    end while (!(bus.zigzag_input_enable && bus.matrix_row == 3) && guard < 100);
    chk("reach_row3", guard < 100, 1);
    n0 = done_comp.size();
    @(posedge clock); #1;
    pulse_reset();
    chk("row_reset_busy", bus.busy, 0);
    chk("row_reset_blk", bus.blk_pix, 0);
    repeat (30) @(posedge clock);
    #1;
    chk("no_done_after_row_reset", done_comp.size(), n0);
    // reset after 30 pixels of a partial fill
    send_block(2'b00, 50, 1'b0, 30);
    pulse_reset();
    chk("partial_reset_ready", bus.pix_ready, 1);
    send_block(2'b01, 100, 1'b1, N);
    repeat (30) @(posedge clock);
    #1;
    chk("post_reset_done_count", done_comp.size(), n0 + 1);
    if (done_comp.size() == n0 + 1) begin
      chk("post_reset_comp", done_comp[n0], 0);
      chk("post_reset_mcu", done_mcu[n0], 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/jpeg_block_sequencer.md
# jpeg_block_sequencer

Self-timed front-end sequencer for the JPEG encoder pipeline. It gathers a streamed 8x8 (parametrised) pixel block into an input buffer and hands it to a held block register. It then sequences the per-stage strobes (DCT start, DCT capture, per-row quantize/zigzag) internally, replacing the externally driven enables. Component order (grayscale, 4:4:4, optional 4:2:0) is tracked per block, and `is_luminance` is driven to the quantize and Huffman stages. A valid/ready input handshake lets the next block fill while the current one is processed.

## Interface
- `PIX_WIDTH`, 8, bits per pixel
- `BLK_DIM`, 8, block edge; block holds N = BLK_DIM*BLK_DIM pixels; ROW_W = $clog2(BLK_DIM)
- `DCT_LAT`, 4, DCT wait cycles between `dct_enable` and `dct_input_enable`; must be >= 1
- `QUANT_LAT`, 1, extra cycles per quantize row before `zigzag_input_enable`
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `pix_valid`  in  1  input pixel valid
- `pix_ready`  out  1  input buffer can accept
- `pix_data`  in  PIX_WIDTH  pixel, raster order within block
- `mode`  in  2  00 gray, 01 4:4:4, 10 4:2:0, 11 reserved (= gray)
- `blk_pix`  out  N*PIX_WIDTH  held block to DCT; pixel i at bits [i*PIX_WIDTH +: PIX_WIDTH]
- `dct_enable`  out  1  one-cycle DCT start strobe
- `dct_input_enable`  out  1  one-cycle DCT result capture strobe
- `matrix_row`  out  ROW_W  current quantize row index
- `zigzag_input_enable`  out  1  one-cycle row write strobe into zigzag buffer
- `is_luminance`  out  1  high when `comp_id` == 0
- `comp_id`  out  2  component of block in process: 0 Y, 1 Cb, 2 Cr
- `blk_done`  out  1  one-cycle pulse, block finished
- `mcu_done`  out  1  one-cycle pulse with `blk_done` on last block of the component sequence
- `busy`  out  1  process FSM not in S_IDLE

## Operation
- Fill side: `fill_cnt` 0..N-1. On accept (`pix_valid && pix_ready`), write `pix_data` to buffer[fill_cnt] and increment. On accepting index N-1, wrap to 0 and set `buf_full`. `pix_ready` = !`buf_full`, registered.
- Process FSM, all outputs registered and Moore-decoded:
  - S_IDLE: if `buf_full`, perform the transfer: copy buffer to `blk_pix`, clear `buf_full`, latch `mode`, resolve `comp_id`, then go to S_DCT.
  - S_DCT: 1 cycle, `dct_enable`=1, then S_WAIT.
  - S_WAIT: DCT_LAT cycles, then S_CAP.
  - S_CAP: 1 cycle, `dct_input_enable`=1, then S_ROW.
  - S_ROW: `matrix_row` r = 0..BLK_DIM-1, each held QUANT_LAT+1 cycles. `zigzag_input_enable`=1 in the last cycle of each row. After row BLK_DIM-1, go to S_DONE.
  - S_DONE: 1 cycle, `blk_done`=1 (`mcu_done` if applicable), advance `seq_idx`, then S_IDLE.
- Component sequence per mode:
  - gray: Y.
  - 4:4:4: Y, Cb, Cr.
  - 4:2:0: Y, Y, Y, Y, Cb, Cr.
  - `seq_idx` wraps to 0 after the last entry.
  - If the `mode` sampled at transfer differs from the latched mode, `seq_idx` restarts at 0 for that block.
- `blk_pix`, `comp_id`, `is_luminance` are stable from the transfer until the next transfer.
- Fill continues during processing; transfer and accept never coincide, because no accept is possible while `buf_full`=1.

## Timing
- Reset values:
  - `pix_ready`=0 during reset, 1 on the first cycle after.
  - All strobes, `busy`, `matrix_row`, `comp_id`, `seq_idx`, `fill_cnt` = 0; `blk_pix` = 0; `is_luminance`=1.
- Last pixel accepted at cycle t:
  - `buf_full`/transfer at t+1.
  - `dct_enable` at t+2.
  - `dct_input_enable` at t+3+DCT_LAT.
  - Row 0 begins at t+4+DCT_LAT.
  - `blk_done` at t+4+DCT_LAT+BLK_DIM*(QUANT_LAT+1). With defaults this is t+24.
- `pix_ready` returns to 1 at t+2.
- Back-to-back blocks need no idle beyond the fill time whenever N >= the processing period. With defaults the processing period is 24 cycles.
- Reset mid-operation: partial fill discarded, FSM to S_IDLE, no `blk_done` emitted.
- `pix_valid` held low mid-block: fill pauses, no timeout.

## Configuration
- `JPEG_SEQ_SUBSAMPLE_420_EN` defined: mode 10 runs the Y,Y,Y,Y,Cb,Cr sequence, and `mcu_done` fires on the Cr block.
- Undefined: 4:2:0 sequencing logic is not compiled. Mode 10 behaves as 4:4:4 (Y, Cb, Cr).

## Test plan
- Reset, then stream 64 pixels 0..63 in gray mode with `pix_valid` always 1:
  - `blk_pix` pixel i = i.
  - `dct_enable` 2 cycles after the last accept; `dct_input_enable` 7 after; `blk_done` 24 after.
  - 8 `zigzag_input_enable` pulses, spaced 2 cycles apart, with `matrix_row` 0..7.
  - `mcu_done`=1 on every block; `is_luminance`=1.
- Mode 01, three back-to-back blocks:
  - `comp_id` 0, 1, 2.
  - `is_luminance` 1, 0, 0.
  - `mcu_done` only on the third block.
  - `pix_ready` never low for more than 1 cycle.
- Macro defined, mode 10, six blocks: `comp_id` 0,0,0,0,1,2 and `mcu_done` on block 6. Macro undefined: `comp_id` 0,1,2,0,1,2.
- Switch `mode` from 01 to 00 after one Y block: next block `comp_id`=0, `mcu_done`=1.
- Random `pix_valid` gaps (50% duty): pixel order preserved, only 64 accepts per block, `blk_pix` matches the reference model.
- Assert `reset` during S_ROW and at `fill_cnt`=30:
  - All outputs return to reset values, with no `blk_done`.
  - The next full 64-pixel block processes correctly with `comp_id`=0.
